carry_select_seq_adder: RTL and testbench

//   Sequencer that time-multiplexes one carry_select_cell across a wide addition.
//   It accepts WIDTH*CHUNKS-bit operands and adds them one WIDTH-bit chunk per cycle, LSB chunk first.
//   A registered carry links each chunk to the next.

---
 rtl/carry_select_seq_adder.sv | 132 +++++++++++++
 tb/tb_carry_select_seq_adder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/carry_select_seq_adder.sv
// Wide unsigned adder built from a single carry_select_cell reused once per chunk, LSB chunk first.
// Valid/ready handshakes on both the operand and the result sides.

module carry_select_cell #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] r0;
  logic [WIDTH:0] r1;

  // Both carry-in outcomes are computed up front; cin only drives the final mux.
  assign r0          = {1'b0, a} + {1'b0, b};
  assign r1          = r0 + {{WIDTH{1'b0}}, 1'b1};
  assign {cout, sum} = cin ? r1 : r0;
endmodule

module carry_select_seq_adder #(
  parameter int WIDTH  = 8,
  parameter int CHUNKS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH*CHUNKS-1:0] a,
  input  logic [WIDTH*CHUNKS-1:0] b,
  input  logic                    carry_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH*CHUNKS-1:0] sum,
  output logic                    carry_out,
  output logic                    busy
);
  localparam int N     = WIDTH * CHUNKS;
  localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic [N-1:0]     sum_q;
  logic             carry_q;
  logic             carry_out_q;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] cell_a;
  logic [WIDTH-1:0] cell_b;
  logic [WIDTH-1:0] cell_sum;
  logic             cell_cout;
  logic             accept;
  logic             last;

  assign cell_a = a_q[idx*WIDTH +: WIDTH];
  assign cell_b = b_q[idx*WIDTH +: WIDTH];
  assign accept = in_valid && (state == IDLE);
  assign last   = (idx == LAST_IDX);

  carry_select_cell #(
    .WIDTH(WIDTH)
  ) u_cell (
    .a   (cell_a),
    .b   (cell_b),
    .cin (carry_q),
    .sum (cell_sum),
    .cout(cell_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      idx         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= carry_in;
            idx     <= '0;
          end
        end
        RUN: begin
          sum_q[idx*WIDTH +: WIDTH] <= cell_sum;
          carry_q                   <= cell_cout;
          if (last) begin
            carry_out_q <= cell_cout;
            idx         <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_q;
  assign carry_out = carry_out_q;
endmodule

// File: tb/tb_carry_select_seq_adder.sv
// Self-checking bench for carry_select_seq_adder (WIDTH=8, CHUNKS=4) against a 33-bit arithmetic model.
`timescale 1ns/1ps

module tb_carry_select_seq_adder;
  localparam int WIDTH  = 8;
  localparam int CHUNKS = 4;
  localparam int N      = WIDTH * CHUNKS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         carry_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] sum;
  logic         carry_out;
  logic         busy;

  int checks = 0;
  int errors = 0;

  carry_select_seq_adder #(
    .WIDTH (WIDTH),
    .CHUNKS(CHUNKS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .carry_in (carry_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .carry_out(carry_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{N{1'b0}}, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for in_ready, then presents one operand set for a single accept edge.
  task automatic send(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tci, output bit ok);
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    ok       = in_ready;
    a        = ta;
    b        = tb;
    carry_in = tci;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc, output bit ok);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    ok = out_valid;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, busy, carry_out} !== 4'b1000 || sum !== '0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b co=%b sum=%h, required 1 0 0 0 00000000",
               in_ready, out_valid, busy, carry_out, sum);
    end
  endtask

  task automatic test_carry_ripple();
    bit ok;
    int cyc;
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, ok);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ripple_busy: busy=%b in_ready=%b, required 1 0", busy, in_ready);
    end
    wait_valid(cyc, ok);
    checks++;
    if (!ok || cyc != CHUNKS) begin
      errors++;
      $display("FAIL ripple_latency: got %0d cycles (valid=%b), required %0d", cyc, ok, CHUNKS);
    end
    checks++;
    if (sum !== 32'h0 || carry_out !== 1'b1) begin
      errors++;
      $display("FAIL ripple_result: sum=%h co=%b, required 00000000 1", sum, carry_out);
    end
    consume();
  endtask

  task automatic test_basic();
    bit ok;
    int cyc = 0;
    int ready_seen = 0;
    send(32'h1234_5678, 32'h1111_1111, 1'b1, ok);
    while (!out_valid && cyc < 100) begin
      if (in_ready) ready_seen++;
      tick();
      cyc++;
    end
    if (in_ready) ready_seen++;
    checks++;
    if (ready_seen != 0 || !out_valid) begin
      errors++;
      $display("FAIL basic_in_ready: in_ready high %0d cycles (valid=%b), required 0", ready_seen, out_valid);
    end
    checks++;
    if (sum !== 32'h2345_678A || carry_out !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: sum=%h co=%b, required 2345678a 0", sum, carry_out);
    end
    consume();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int cyc;
    int bad = 0;
    logic [N:0] exp;
    exp = model(32'hDEAD_BEEF, 32'h3050_1234, 1'b1);
    send(32'hDEAD_BEEF, 32'h3050_1234, 1'b1, ok);
    wait_valid(cyc, ok);
    for (int i = 0; i < 10; i++) begin
      if ({carry_out, sum} !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL backpressure_hold: %0d unstable cycles, last sum=%h co=%b valid=%b in_ready=%b, required sum=%h co=%b 1 0",
               bad, sum, carry_out, out_valid, in_ready, exp[N-1:0], exp[N]);
    end
    consume();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b busy=%b, required 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_input_change();
    bit ok;
    int cyc = 0;
    logic [N:0] exp;
    exp = model(32'h0F0F_F0F0, 32'h7777_9999, 1'b0);
    send(32'h0F0F_F0F0, 32'h7777_9999, 1'b0, ok);
    while (!out_valid && cyc < 100) begin
      a        = $urandom;
      b        = $urandom;
      carry_in = 1'($urandom);
      tick();
      cyc++;
    end
    checks++;
    if ({carry_out, sum} !== exp || !out_valid) begin
      errors++;
      $display("FAIL input_change: sum=%h co=%b valid=%b, required %h %b", sum, carry_out, out_valid, exp[N-1:0], exp[N]);
    end
    consume();
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int cyc;
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, ok);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, busy, carry_out} !== 4'b1000 || sum !== '0) begin
      errors++;
      $display("FAIL reset_mid_run: in_ready=%b out_valid=%b busy=%b co=%b sum=%h, required 1 0 0 0 00000000",
               in_ready, out_valid, busy, carry_out, sum);
    end
    send(32'h8000_0000, 32'h8000_0000, 1'b0, ok);
    wait_valid(cyc, ok);
    checks++;
    if (!ok || sum !== 32'h0 || carry_out !== 1'b1) begin
      errors++;
      $display("FAIL after_reset_add: sum=%h co=%b valid=%b, required 00000000 1 1", sum, carry_out, ok);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int cyc;
    int n;
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic rc;
    logic [N:0] exp;
    for (int i = 0; i < 1000; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rc  = 1'($urandom);
      if (i % 7 == 0) ra = '1;
      exp = model(ra, rb, rc);
      send(ra, rb, rc, ok);
      wait_valid(cyc, ok);
      checks++;
      if (!ok || cyc != CHUNKS || {carry_out, sum} !== exp) begin
        errors++;
        $display("FAIL random_op %0d: sum=%h co=%b latency=%0d, required %h %b %0d",
                 i, sum, carry_out, cyc, exp[N-1:0], exp[N], CHUNKS);
      end
      n = 0;
      do begin
        out_ready = 1'($urandom);
        tick();
        n++;
        if (out_ready) break;
        checks++;
        if (out_valid !== 1'b1 || {carry_out, sum} !== exp) begin
          errors++;
          $display("FAIL random_stall %0d: valid=%b sum=%h co=%b, required 1 %h %b",
                   i, out_valid, sum, carry_out, exp[N-1:0], exp[N]);
        end
      end while (n < 50);
      out_ready = 1'b0;
      if (out_valid) consume();
    end
  endtask

  initial begin
    test_reset();
    test_carry_ripple();
    test_basic();
    test_backpressure();
    test_input_change();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
